// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: FSM state encoding, parity modes
// and the word format stored in the receive FIFO.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int MAX_DATA_BITS = 9;

    // Sized for the widest frame; narrower configs leave upper data bits zero.
    typedef struct packed {
        logic                     perr;
        logic                     ferr;
        logic [MAX_DATA_BITS-1:0] data;
    } rx_word_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; a push into a full FIFO succeeds only when a pop
// frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronizer, mid-bit sampling FSM with
// parity/framing/break detection, feeding a show-ahead FIFO.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_perr,
    output logic                 m_ferr,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_DLAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_SLAST = IDX_W'(STOP_BITS - 1);

    logic [1:0]           sync_q;
    logic                 rxs;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 zero_q, zero_d;
    logic                 brkw_q, brkw_d;

    logic     sample, zero_fin, fin_stop;
    logic     push, brk;
    rx_word_t push_word, head;
    logic     fifo_full, fifo_empty, pop;

    assign rxs      = sync_q[1];
    assign sample   = (cnt_q == CNT_LAST);
    // Break looks at data, parity and only the first stop bit.
    assign zero_fin = zero_q & ((idx_q != '0) | ~rxs);
    assign fin_stop = (state_q == ST_STOP) && sample && (idx_q == IDX_SLAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            zero_q  <= 1'b0;
            brkw_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            zero_q  <= zero_d;
            brkw_q  <= brkw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        par_d   = par_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        zero_d  = zero_q;
        brkw_d  = brkw_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (brkw_q) begin
                    if (rxs) brkw_d = 1'b0;
                end else if (!rxs) begin
                    state_d = ST_START;
                    idx_d   = '0;
                    par_d   = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    zero_d  = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (sample) begin
                    cnt_d  = '0;
                    data_d = {rxs, data_q[DATA_BITS-1:1]};
                    par_d  = par_q ^ rxs;
                    zero_d = zero_q & ~rxs;
                    if (idx_q == IDX_DLAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (sample) begin
                    cnt_d   = '0;
                    perr_d  = (PARITY == PAR_ODD) ? ~(par_q ^ rxs) : (par_q ^ rxs);
                    zero_d  = zero_q & ~rxs;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (sample) begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~rxs;
                    zero_d = zero_fin;
                    if (idx_q == IDX_SLAST) begin
                        state_d = ST_IDLE;
                        brkw_d  = zero_fin;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_q != ST_IDLE);
        push           = fin_stop & ~zero_fin & ~rst;
        brk            = fin_stop & zero_fin & ~rst;
        push_word      = '0;
        push_word.perr = perr_q;
        push_word.ferr = ferr_q | ~rxs;
        push_word.data = MAX_DATA_BITS'(data_q);
    end

    uart_rx_fifo #(
        .WIDTH ($bits(rx_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_word),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o ()
    );

    assign m_valid   = ~fifo_empty;
    assign pop       = m_valid & m_ready;
    assign m_data    = head.data[DATA_BITS-1:0];
    assign m_perr    = head.perr;
    assign m_ferr    = head.ferr;
    assign overrun   = push & fifo_full & ~pop;
    assign break_det = brk;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench: a default 8N1 receiver and a 7E2 receiver with a 2-deep FIFO.
module tb_uart_rx_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rx_a, rdy_a, pe_a, fe_a, v_a, ov_a, bk_a, bz_a;
    logic [7:0] d_a;
    logic rx_b, rdy_b, pe_b, fe_b, v_b, ov_b, bk_b, bz_b;
    logic [6:0] d_b;

    uart_rx_cfg u_a (
        .clk(clk), .rst(rst), .rx(rx_a), .m_data(d_a), .m_perr(pe_a), .m_ferr(fe_a),
        .m_valid(v_a), .m_ready(rdy_a), .overrun(ov_a), .break_det(bk_a), .busy(bz_a)
    );

    uart_rx_cfg #(
        .CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(2)
    ) u_b (
        .clk(clk), .rst(rst), .rx(rx_b), .m_data(d_b), .m_perr(pe_b), .m_ferr(fe_b),
        .m_valid(v_b), .m_ready(rdy_b), .overrun(ov_b), .break_det(bk_b), .busy(bz_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Popped words are recorded as {perr, ferr, data[8:0]}.
    logic [10:0] wa [64];
    logic [10:0] wb [64];
    int na = 0, ova = 0, bka = 0, bza = 0, vca = 0;
    int nb = 0, bzb = 0;

    always begin
        @(negedge clk);
        #2;
        if (v_a && rdy_a) begin
            if (na < 64) wa[na] = {pe_a, fe_a, 1'b0, d_a};
            na++;
        end
        if (v_b && rdy_b) begin
            if (nb < 64) wb[nb] = {pe_b, fe_b, 2'b00, d_b};
            nb++;
        end
        if (ov_a) ova++;
        if (bk_a) bka++;
        if (bz_a) bza++;
        if (v_a)  vca++;
        if (bz_b) bzb++;
    end

    task automatic send(input bit sel, input logic [15:0] bits, input int n, input int cpb);
        for (int i = 0; i < n; i++) begin
            if (sel) rx_b = bits[i];
            else     rx_a = bits[i];
            repeat (cpb) @(negedge clk);
        end
    endtask

    function automatic logic [15:0] frm_a(input logic [7:0] d);
        return {6'h3f, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [15:0] frm_b(input logic [6:0] d, input logic par, input logic s2);
        return {5'h1f, s2, 1'b1, par, d, 1'b0};
    endfunction

    initial begin
        int n0, o0, b0, z0, v0;
        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_valid", v_a, 0);
        chk("rst_busy", bz_a, 0);
        chk("rst_ovr", ov_a, 0);
        chk("rst_brk", bk_a, 0);
        chk("rst_valid_b", v_b, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 0xA5, consumer always ready
        v0 = vca;
        send(0, frm_a(8'hA5), 10, 16);
        repeat (32) @(negedge clk);
        chk("a5_count", na, 1);
        chk("a5_data", wa[0][8:0], 9'h0A5);
        chk("a5_perr", wa[0][10], 0);
        chk("a5_ferr", wa[0][9], 0);
        chk("a5_valid_cycles", vca - v0, 1);

        // Overrun: five frames into a 4-deep FIFO with no consumer
        rdy_a = 1'b0;
        n0 = na; o0 = ova;
        for (int k = 1; k <= 4; k++) send(0, frm_a(8'(k)), 10, 16);
        repeat (32) @(negedge clk);
        chk("ovr_before", ova - o0, 0);
        chk("ovr_valid", v_a, 1);
        send(0, frm_a(8'h05), 10, 16);
        repeat (32) @(negedge clk);
        chk("ovr_pulse", ova - o0, 1);
        rdy_a = 1'b1;
        repeat (8) @(negedge clk);
        chk("ovr_popped", na - n0, 4);
        for (int k = 0; k < 4; k++) chk("ovr_word", wa[n0 + k][8:0], 32'(k + 1));
        chk("ovr_empty", v_a, 0);

        // Break: line low for two frame times
        n0 = na; b0 = bka;
        rx_a = 1'b0;
        repeat (12 * 16) @(negedge clk);
        z0 = bza;
        repeat (8 * 16) @(negedge clk);
        chk("brk_pulse", bka - b0, 1);
        chk("brk_nopush", na - n0, 0);
        chk("brk_quiet", bza - z0, 0);
        chk("brk_busy", bz_a, 0);
        rx_a = 1'b1;
        repeat (32) @(negedge clk);
        send(0, frm_a(8'h5A), 10, 16);
        repeat (32) @(negedge clk);
        chk("brk_after_cnt", na - n0, 1);
        chk("brk_after_data", wa[n0][8:0], 9'h05A);

        // Reset mid-frame with two words queued
        rdy_a = 1'b0;
        o0 = ova; b0 = bka;
        send(0, frm_a(8'h11), 10, 16);
        send(0, frm_a(8'h22), 10, 16);
        send(0, frm_a(8'h33), 4, 16);
        chk("rmid_valid_pre", v_a, 1);
        chk("rmid_busy_pre", bz_a, 1);
        rst = 1'b1; rx_a = 1'b1;
        @(negedge clk);
        chk("rmid_valid", v_a, 0);
        chk("rmid_busy", bz_a, 0);
        rst = 1'b0;
        repeat (32) @(negedge clk);
        chk("rmid_nopulse", (ova - o0) + (bka - b0), 0);
        n0 = na;
        rdy_a = 1'b1;
        send(0, frm_a(8'h3C), 10, 16);
        repeat (32) @(negedge clk);
        chk("rmid_cnt", na - n0, 1);
        chk("rmid_data", wa[n0][8:0], 9'h03C);
        chk("rmid_ferr", wa[n0][9], 0);

        // 7E2: 0x53 has four ones, so even parity bit is 0
        send(1, frm_b(7'h53, 1'b1, 1'b1), 11, 8);
        repeat (16) @(negedge clk);
        send(1, frm_b(7'h53, 1'b0, 1'b1), 11, 8);
        repeat (16) @(negedge clk);
        chk("par_cnt", nb, 2);
        chk("par_bad_data", wb[0][8:0], 9'h053);
        chk("par_bad_perr", wb[0][10], 1);
        chk("par_bad_ferr", wb[0][9], 0);
        chk("par_ok_perr", wb[1][10], 0);

        // 0x2A has three ones -> parity 1; second stop bit low
        send(1, frm_b(7'h2A, 1'b1, 1'b0), 11, 8);
        rx_b = 1'b1;
        repeat (24) @(negedge clk);
        chk("stop2_cnt", nb, 3);
        chk("stop2_data", wb[2][8:0], 9'h02A);
        chk("stop2_ferr", wb[2][9], 1);
        chk("stop2_perr", wb[2][10], 0);

        // Quarter-bit glitch on idle line
        n0 = nb; z0 = bzb;
        rx_b = 1'b0;
        repeat (2) @(negedge clk);
        rx_b = 1'b1;
        repeat (24) @(negedge clk);
        chk("glitch_busy", (bzb - z0) > 0, 1);
        chk("glitch_nopush", nb - n0, 0);
        chk("glitch_idle", bz_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per bit; the legal range SHALL be 4..1024, and the value SHALL be even.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; the legal range SHALL be 5..9.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1: the legal values SHALL be 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4: receive FIFO entries; SHALL be a power of 2 and at least 2.
REQ-006 Port clk, input, 1: clock; all logic SHALL be on its rising edge.
REQ-007 Port rst, input, 1: reset; synchronous, active-high.
REQ-008 Port rx, input, 1: asynchronous serial line; idles high.
REQ-009 Port m_data, output, DATA_BITS: head-of-FIFO data word.
REQ-010 Port m_perr, output, 1: parity error flag of the head word.
REQ-011 Port m_ferr, output, 1: framing error flag of the head word.
REQ-012 Port m_valid, output, 1: the FIFO is non-empty.
REQ-013 Port m_ready, input, 1: consumer accepts the head word.
REQ-014 Port overrun, output, 1: one-cycle pulse when a completed frame is dropped.
REQ-015 Port break_det, output, 1: one-cycle pulse when a break is detected.
REQ-016 Port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-017 rx SHALL pass through a 2-FF synchronizer; the FSM SHALL use only the synchronized value (rxs).
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; one bit counter (0..CLKS_PER_BIT-1) and one bit index SHALL be used.
REQ-019 IDLE: rxs==0 SHALL move the FSM to START with the counter cleared.
REQ-020 START: at counter==CLKS_PER_BIT/2-1, rxs is sampled; if rxs==1 (glitch), the FSM SHALL return to IDLE with no flags; otherwise it SHALL move to DATA with the counter cleared.
REQ-021 DATA/PARITY/STOP: each bit SHALL be sampled at counter==CLKS_PER_BIT-1, which is mid-bit because of the half-bit offset from START.
REQ-022 DATA bits SHALL be received LSB first; after DATA_BITS samples, the FSM SHALL go to PARITY if PARITY!=0, else to STOP.
REQ-023 The parity error flag SHALL be set when (XOR of data bits) XOR (parity bit) is 1 for even parity, or is 0 for odd parity; with PARITY==0, m_perr SHALL be 0.
REQ-024 STOP: STOP_BITS samples SHALL be taken; the framing error flag SHALL be set if any stop sample is 0.
REQ-025 At the final stop sample, the FSM SHALL return to IDLE in the same cycle, so a start bit immediately following the stop bit is accepted.
REQ-026 At the final stop sample, {perr, ferr, data} SHALL be pushed into the FIFO; m_valid SHALL rise in the next cycle if the FIFO was empty.
REQ-027 Break: if all data bits, the parity bit (if any) and the first stop bit are all 0, break_det SHALL pulse at the final stop sample, no word SHALL be pushed, and the FSM SHALL stay in IDLE-wait until rxs==1 before accepting a new start.
REQ-028 Push with the FIFO full and no pop in the same cycle: the word SHALL be dropped and overrun SHALL pulse; the FIFO contents SHALL be unchanged.
REQ-029 Push and pop in the same cycle with the FIFO full SHALL both succeed, with no overrun.
REQ-030 A pop SHALL occur when m_valid && m_ready; pop on empty SHALL have no effect.
REQ-031 The FIFO SHALL be show-ahead: m_data, m_perr and m_ferr SHALL be valid combinationally from the head while m_valid==1.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL use clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-033 On rst, the FSM SHALL go to IDLE; the counters and FIFO pointers/count SHALL clear; the synchronizer flops SHALL go to 1.
REQ-034 On rst, m_valid, overrun, break_det and busy SHALL be 0; FIFO storage is not reset.
REQ-035 rst mid-frame SHALL discard the partial frame and all FIFO contents, and SHALL produce no overrun or break pulse.

Structure
REQ-036 Package uart_pkg SHALL hold the state enum, the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and an rx word struct {perr, ferr, data}.
REQ-037 The FIFO SHALL be the sub-module uart_rx_fifo (parameters WIDTH and DEPTH; push/pop/full/empty/count).

Verification
REQ-038 Default parameters, frame 0xA5 sent 8N1, m_ready=1 -> m_data=0xA5, m_perr=0, m_ferr=0, m_valid high for 1 cycle, 2 cycles after the stop-bit mid-sample.
REQ-039 PARITY=1, DATA_BITS=7, byte 0x53 sent with a wrong parity bit -> m_data=0x53, m_perr=1, m_ferr=0.
REQ-040 STOP_BITS=2, second stop bit driven 0 -> m_ferr=1 and the word is pushed; a 0.25-bit low glitch on idle rx -> busy pulses, no word pushed.
REQ-041 FIFO_DEPTH=4, m_ready=0, 5 frames 0x01..0x05 -> overrun pulses once at frame 5; popping then yields 0x01..0x04.
REQ-042 rx held low for 2 frame times -> break_det pulses once, no word pushed, no further activity until rx returns high.
REQ-043 rst asserted mid-DATA with 2 words queued -> m_valid=0 the next cycle; a following 0x3C frame is received correctly.
